// File: rtl/data_sync_mc.sv
// ---------------------------------------------------------------------------
// data_sync_mc
//   Multi-channel enable-qualified data synchronizer, entirely in the CLK
//   domain. Each channel passes its unsynchronized enable through a
//   NUM_STAGES flop chain. It then edge-detects the synchronized enable:
//   a rising edge in level mode (EN_MODE=0), or any edge in toggle mode
//   (EN_MODE=1). On a detected edge the channel captures its quasi-static
//   bus. A valid/ready hold register presents the captured word to the
//   consumer, and a sticky flag records overwrites of unconsumed data.
//
// Ports
//   CLK           in   destination clock
//   RST           in   asynchronous active-low reset
//   bus_enable    in   [NUM_CH]            unsynchronized enable per channel
//   unsync_bus    in   [NUM_CH*BUS_WIDTH]  channel c at [c*BUS_WIDTH +: BUS_WIDTH]
//   sync_ready    in   [NUM_CH]            consumer takes the held word
//   overrun_clr   in   1                   clears every overrun flag
//   sync_bus      out  [NUM_CH*BUS_WIDTH]  captured data, held until next capture
//   enable_pulse  out  [NUM_CH]            one-cycle registered capture strobe
//   sync_valid    out  [NUM_CH]            held word not yet consumed
//   overrun       out  [NUM_CH]            sticky: capture hit an unconsumed word
// ---------------------------------------------------------------------------
module data_sync_mc #(
  parameter int BUS_WIDTH  = 8,
  parameter int NUM_STAGES = 2,   // legal range 2..4
  parameter int NUM_CH     = 2,
  parameter int EN_MODE    = 0    // 0 = level, 1 = toggle
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_CH-1:0]           bus_enable,
  input  logic [NUM_CH*BUS_WIDTH-1:0] unsync_bus,
  input  logic [NUM_CH-1:0]           sync_ready,
  input  logic                        overrun_clr,
  output logic [NUM_CH*BUS_WIDTH-1:0] sync_bus,
  output logic [NUM_CH-1:0]           enable_pulse,
  output logic [NUM_CH-1:0]           sync_valid,
  output logic [NUM_CH-1:0]           overrun
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [NUM_STAGES-1:0] sync_reg;
      logic                  prev_reg;
      logic                  sync_en;
      logic                  det;
      logic [BUS_WIDTH-1:0]  bus_reg;
      logic                  pulse_reg;
      logic                  valid_reg;
      logic                  valid_next;
      logic                  overrun_reg;
      logic                  overrun_next;

      assign sync_en = sync_reg[NUM_STAGES-1];

      // Level mode only reacts to a rise, so a held enable captures once;
      // toggle mode treats every transition of the source as an event.
      assign det = (EN_MODE != 0) ? (sync_en ^ prev_reg) : (sync_en & ~prev_reg);

      // Synchronizer chain plus one edge-history flop.
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          sync_reg <= '0;
          prev_reg <= 1'b0;
        end else begin
          sync_reg <= {sync_reg[NUM_STAGES-2:0], bus_enable[gi]};
          prev_reg <= sync_en;
        end
      end

      // A capture always re-arms valid, even when the consumer takes the
      // previous word on the same edge: the new word replaces it.
      always_comb begin
        valid_next = valid_reg;
        if (det) begin
          valid_next = 1'b1;
        end else if (sync_ready[gi]) begin
          valid_next = 1'b0;
        end
      end

      // Overrun set has priority over the clear so that an overwrite on
      // the clearing edge is not lost.
      always_comb begin
        overrun_next = overrun_reg;
        if (overrun_clr) begin
          overrun_next = 1'b0;
        end
        if (det && valid_reg && !sync_ready[gi]) begin
          overrun_next = 1'b1;
        end
      end

      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          bus_reg     <= '0;
          pulse_reg   <= 1'b0;
          valid_reg   <= 1'b0;
          overrun_reg <= 1'b0;
        end else begin
          if (det) begin
            bus_reg <= unsync_bus[gi*BUS_WIDTH +: BUS_WIDTH];
          end
          pulse_reg   <= det;
          valid_reg   <= valid_next;
          overrun_reg <= overrun_next;
        end
      end

      assign sync_bus[gi*BUS_WIDTH +: BUS_WIDTH] = bus_reg;
      assign enable_pulse[gi]                    = pulse_reg;
      assign sync_valid[gi]                      = valid_reg;
      assign overrun[gi]                         = overrun_reg;
    end
  endgenerate

endmodule

// File: tb/tb_data_sync_mc.sv
// ---------------------------------------------------------------------------
// tb_data_sync_mc
//   Table-driven check of the level-mode channel behaviour on a
//   NUM_STAGES=2 instance. Hand-written sequences cover reset in the middle
//   of a transfer and toggle mode on a NUM_STAGES=3 instance.
// ---------------------------------------------------------------------------
module tb_data_sync_mc;

  logic        clk;
  logic        rst_n;

  // level-mode instance (NUM_STAGES=2)
  logic [1:0]  en;
  logic [15:0] bus;
  logic [1:0]  rdy;
  logic        clr;
  logic [15:0] sbus;
  logic [1:0]  pulse;
  logic [1:0]  valid;
  logic [1:0]  ovr;

  // toggle-mode instance (NUM_STAGES=3)
  logic [1:0]  en_t;
  logic [15:0] bus_t;
  logic [1:0]  rdy_t;
  logic        clr_t;
  logic [15:0] sbus_t;
  logic [1:0]  pulse_t;
  logic [1:0]  valid_t;
  logic [1:0]  ovr_t;

  int n_checks = 0;
  int n_fail   = 0;

  data_sync_mc #(.BUS_WIDTH(8), .NUM_STAGES(2), .NUM_CH(2), .EN_MODE(0)) u_lvl (
    .CLK(clk), .RST(rst_n), .bus_enable(en), .unsync_bus(bus), .sync_ready(rdy),
    .overrun_clr(clr), .sync_bus(sbus), .enable_pulse(pulse), .sync_valid(valid),
    .overrun(ovr)
  );

  data_sync_mc #(.BUS_WIDTH(8), .NUM_STAGES(3), .NUM_CH(2), .EN_MODE(1)) u_tgl (
    .CLK(clk), .RST(rst_n), .bus_enable(en_t), .unsync_bus(bus_t), .sync_ready(rdy_t),
    .overrun_clr(clr_t), .sync_bus(sbus_t), .enable_pulse(pulse_t), .sync_valid(valid_t),
    .overrun(ovr_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  en;
    logic [15:0] bus;
    logic [1:0]  rdy;
    logic        clr;
    logic [15:0] e_bus;
    logic [1:0]  e_p;
    logic [1:0]  e_v;
    logic [1:0]  e_o;
  } vec_t;

  vec_t tbl [100];
  int   n_vec = 0;

  task automatic add(input logic [1:0] a_en, input logic [15:0] a_bus,
                     input logic [1:0] a_rdy, input logic a_clr,
                     input logic [15:0] a_eb, input logic [1:0] a_ep,
                     input logic [1:0] a_ev, input logic [1:0] a_eo);
    tbl[n_vec].en    = a_en;
    tbl[n_vec].bus   = a_bus;
    tbl[n_vec].rdy   = a_rdy;
    tbl[n_vec].clr   = a_clr;
    tbl[n_vec].e_bus = a_eb;
    tbl[n_vec].e_p   = a_ep;
    tbl[n_vec].e_v   = a_ev;
    tbl[n_vec].e_o   = a_eo;
    n_vec++;
  endtask

  task automatic addn(input int n, input logic [1:0] a_en, input logic [15:0] a_bus,
                      input logic [1:0] a_rdy, input logic a_clr,
                      input logic [15:0] a_eb, input logic [1:0] a_ep,
                      input logic [1:0] a_ev, input logic [1:0] a_eo);
    for (int i = 0; i < n; i++) add(a_en, a_bus, a_rdy, a_clr, a_eb, a_ep, a_ev, a_eo);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    en = '0; bus = '0; rdy = '0; clr = 1'b0;
    en_t = '0; bus_t = '0; rdy_t = '0; clr_t = 1'b0;

    // ---------------- table fill ----------------
    // capture A5 three edges after the rise, then hold enable high
    addn(2,  2'b01, 16'h00A5, 2'b00, 1'b0, 16'h0000, 2'b00, 2'b00, 2'b00);
    add (    2'b01, 16'h00A5, 2'b00, 1'b0, 16'h00A5, 2'b01, 2'b01, 2'b00);
    addn(21, 2'b01, 16'h00A5, 2'b00, 1'b0, 16'h00A5, 2'b00, 2'b01, 2'b00);
    // handshake consumes word; ready ignored while not valid
    add (    2'b01, 16'h00A5, 2'b01, 1'b0, 16'h00A5, 2'b00, 2'b00, 2'b00);
    add (    2'b01, 16'h00A5, 2'b00, 1'b0, 16'h00A5, 2'b00, 2'b00, 2'b00);
    add (    2'b01, 16'h00A5, 2'b01, 1'b0, 16'h00A5, 2'b00, 2'b00, 2'b00);
    // capture 77
    addn(3,  2'b00, 16'h0077, 2'b00, 1'b0, 16'h00A5, 2'b00, 2'b00, 2'b00);
    addn(2,  2'b01, 16'h0077, 2'b00, 1'b0, 16'h00A5, 2'b00, 2'b00, 2'b00);
    add (    2'b01, 16'h0077, 2'b00, 1'b0, 16'h0077, 2'b01, 2'b01, 2'b00);
    // capture 3C on the same edge as ready: valid stays, no overrun
    addn(3,  2'b00, 16'h003C, 2'b00, 1'b0, 16'h0077, 2'b00, 2'b01, 2'b00);
    addn(2,  2'b01, 16'h003C, 2'b00, 1'b0, 16'h0077, 2'b00, 2'b01, 2'b00);
    add (    2'b01, 16'h003C, 2'b01, 1'b0, 16'h003C, 2'b01, 2'b01, 2'b00);
    add (    2'b01, 16'h003C, 2'b00, 1'b0, 16'h003C, 2'b00, 2'b01, 2'b00);
    add (    2'b01, 16'h003C, 2'b01, 1'b0, 16'h003C, 2'b00, 2'b00, 2'b00);
    // overrun: 11 then 22 without ready
    addn(3,  2'b00, 16'h0011, 2'b00, 1'b0, 16'h003C, 2'b00, 2'b00, 2'b00);
    addn(2,  2'b01, 16'h0011, 2'b00, 1'b0, 16'h003C, 2'b00, 2'b00, 2'b00);
    add (    2'b01, 16'h0011, 2'b00, 1'b0, 16'h0011, 2'b01, 2'b01, 2'b00);
    addn(3,  2'b00, 16'h0022, 2'b00, 1'b0, 16'h0011, 2'b00, 2'b01, 2'b00);
    addn(2,  2'b01, 16'h0022, 2'b00, 1'b0, 16'h0011, 2'b00, 2'b01, 2'b00);
    add (    2'b01, 16'h0022, 2'b00, 1'b0, 16'h0022, 2'b01, 2'b01, 2'b01);
    add (    2'b01, 16'h0022, 2'b00, 1'b1, 16'h0022, 2'b00, 2'b01, 2'b00);
    // new overrun on the clearing edge wins
    addn(3,  2'b00, 16'h0033, 2'b00, 1'b0, 16'h0022, 2'b00, 2'b01, 2'b00);
    addn(2,  2'b01, 16'h0033, 2'b00, 1'b0, 16'h0022, 2'b00, 2'b01, 2'b00);
    add (    2'b01, 16'h0033, 2'b00, 1'b1, 16'h0033, 2'b01, 2'b01, 2'b01);
    add (    2'b01, 16'h0033, 2'b00, 1'b0, 16'h0033, 2'b00, 2'b01, 2'b01);
    // both channels on the same cycle, each with its own data
    addn(3,  2'b00, 16'hBB44, 2'b00, 1'b0, 16'h0033, 2'b00, 2'b01, 2'b01);
    addn(2,  2'b11, 16'hBB44, 2'b00, 1'b0, 16'h0033, 2'b00, 2'b01, 2'b01);
    add (    2'b11, 16'hBB44, 2'b00, 1'b0, 16'hBB44, 2'b11, 2'b11, 2'b01);
    add (    2'b11, 16'hBB44, 2'b11, 1'b1, 16'hBB44, 2'b00, 2'b00, 2'b00);

    // ---------------- reset state ----------------
    step();
    step();
    chk("reset sync_bus", 32'(sbus), 32'h0);
    chk("reset pulse",    32'(pulse), 32'h0);
    chk("reset valid",    32'(valid), 32'h0);
    chk("reset overrun",  32'(ovr), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---------------- table ----------------
    for (int i = 0; i < n_vec; i++) begin
      en  = tbl[i].en;
      bus = tbl[i].bus;
      rdy = tbl[i].rdy;
      clr = tbl[i].clr;
      step();
      chk($sformatf("vec%0d sync_bus", i), 32'(sbus),  32'(tbl[i].e_bus));
      chk($sformatf("vec%0d pulse", i),    32'(pulse), 32'(tbl[i].e_p));
      chk($sformatf("vec%0d valid", i),    32'(valid), 32'(tbl[i].e_v));
      chk($sformatf("vec%0d overrun", i),  32'(ovr),   32'(tbl[i].e_o));
    end
    rdy = '0; clr = 1'b0;

    // ---------------- reset mid-operation (level mode) ----------------
    en = 2'b00; bus = 16'h0066;
    for (int k = 0; k < 3; k++) step();
    en = 2'b01;
    step();
    step();
    step();
    chk("pre-reset pulse", 32'(pulse), 32'h1);
    chk("pre-reset bus",   32'(sbus),  32'hBB66);
    step();
    chk("pre-reset valid", 32'(valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset bus",     32'(sbus),  32'h0);
    chk("async reset pulse",   32'(pulse), 32'h0);
    chk("async reset valid",   32'(valid), 32'h0);
    chk("async reset overrun", 32'(ovr),   32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("post-reset edge%0d pulse", k), 32'(pulse), (k == 3) ? 32'h1 : 32'h0);
      chk($sformatf("post-reset edge%0d valid", k), 32'(valid), (k >= 3) ? 32'h1 : 32'h0);
      chk($sformatf("post-reset edge%0d bus", k),   32'(sbus),  (k >= 3) ? 32'h0066 : 32'h0);
    end

    // ---------------- toggle mode, NUM_STAGES=3, channel 1 ----------------
    en_t = 2'b10; bus_t = 16'h5A00;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("tgl rise edge%0d pulse", k), 32'(pulse_t), (k == 4) ? 32'h2 : 32'h0);
      chk($sformatf("tgl rise edge%0d bus", k),   32'(sbus_t), (k >= 4) ? 32'h5A00 : 32'h0);
      chk($sformatf("tgl rise edge%0d valid", k), 32'(valid_t),
          (k >= 4 && k < 7) ? 32'h2 : 32'h0);
      if (k == 6) rdy_t = 2'b10;
      if (k == 7) rdy_t = 2'b00;
    end
    en_t = 2'b00; bus_t = 16'hC300;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("tgl fall edge%0d pulse", k), 32'(pulse_t), (k == 4) ? 32'h2 : 32'h0);
      chk($sformatf("tgl fall edge%0d bus", k),   32'(sbus_t), (k >= 4) ? 32'hC300 : 32'h5A00);
      chk($sformatf("tgl fall edge%0d valid", k), 32'(valid_t), (k >= 4) ? 32'h2 : 32'h0);
      chk($sformatf("tgl fall edge%0d overrun", k), 32'(ovr_t), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
